// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM state type and default source count for the interrupt-source controller
package irq_pkg;
  typedef enum logic [1:0] {IDLE, REQ, GAP} irq_state_t;
  localparam int NSRC_DEF = 4;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational fixed-priority encoder, lowest index wins
//   req : N request bits in
//   any : at least one request bit is set
//   idx : index of the lowest set bit (0 when none)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N   = NSRC_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  output logic           any,
  output logic [IDW-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = IDW'(i);
  end
endmodule

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: edge-collecting, masked, fixed-priority interrupt source with ExtIRQ/ExtIAck handshake
//   clk, reset : clock, async active-high reset
//   src        : peripheral lines, rising edge = event
//   mask       : 1 = source may request
//   lost_clr   : 1 = clear matching lost bit
//   ExtIAck    : acknowledge from controller
//   ExtIRQ     : registered request, high only in REQ
//   irq_id     : granted source, frozen during REQ
//   pending    : latched unserviced events
//   lost       : sticky overflow per source
module irq_source_ctrl
  import irq_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = $clog2(NSRC)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] mask,
  input  logic [NSRC-1:0] lost_clr,
  input  logic            ExtIAck,
  output logic            ExtIRQ,
  output logic [IDW-1:0]  irq_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] lost
);
  irq_state_t      state;
  logic [NSRC-1:0] src_q, edge_v, ret_v;
  logic            any;
  logic [IDW-1:0]  idx;
  assign edge_v = src & ~src_q;
  assign ret_v  = (state == REQ && ExtIAck) ? {{(NSRC-1){1'b0}}, 1'b1} << irq_id : '0;
  irq_prio_enc #(.N(NSRC), .IDW(IDW)) u_enc (
    .req (pending & mask),
    .any (any),
    .idx (idx)
  );
  // src_q resets high so a line already asserted at reset release is not an event;
  // in both registers a new edge overrides a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q   <= '1;
      pending <= '0;
      lost    <= '0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~ret_v) | edge_v;
      lost    <= (lost & ~lost_clr) | (edge_v & pending & ~ret_v);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ExtIRQ <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: if (any) begin
          state  <= REQ;
          ExtIRQ <= 1'b1;
          irq_id <= idx;
        end
        REQ: if (ExtIAck) begin
          state  <= GAP;
          ExtIRQ <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          ExtIRQ <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed bench with grant scoreboard for irq_source_ctrl
module tb_irq_source_ctrl;
  logic       clk = 0, reset = 1, exc_ack = 0;
  logic [3:0] src = 0, mask = 0, lost_clr = 0, pending, lost;
  logic       ExtIRQ, ExtIAck;
  logic [1:0] irq_id;
  int         checks = 0, failures = 0;
  int         exp_q[$];
  assign ExtIAck = exc_ack & ExtIRQ;
  always #5 clk = ~clk;
  irq_source_ctrl #(.NSRC(4)) dut (
    .clk(clk), .reset(reset), .src(src), .mask(mask), .lost_clr(lost_clr),
    .ExtIAck(ExtIAck), .ExtIRQ(ExtIRQ), .irq_id(irq_id), .pending(pending), .lost(lost)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic ack_it;
    exc_ack = 1;
    tick;
    exc_ack = 0;
  endtask
  // grant monitor: every rising ExtIRQ pops the expected id and checks the low gap
  bit prev = 0, seen = 0;
  int low_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (ExtIRQ && !prev) begin
      if (seen) chk("gap_ge2", 16'(low_cnt >= 2), 16'd1);
      seen = 1;
      if (exp_q.size() == 0) chk("unexpected_grant", 16'(irq_id), 16'hffff);
      else chk("grant_id", 16'(irq_id), 16'(exp_q.pop_front()));
    end
    low_cnt = ExtIRQ ? 0 : low_cnt + 1;
    prev = ExtIRQ;
  end
  initial begin
    tick;
    tick;
    chk("rst_irq", 16'(ExtIRQ), 0);
    chk("rst_id", 16'(irq_id), 0);
    chk("rst_pend", 16'(pending), 0);
    chk("rst_lost", 16'(lost), 0);
    reset = 0;
    tick;
    // single event
    mask = 4'b1111;
    src = 4'b0100; exp_q.push_back(2);
    tick;
    chk("single_pend", 16'(pending), 16'b0100);
    chk("single_irq_early", 16'(ExtIRQ), 0);
    src = 0;
    tick;
    chk("single_irq", 16'(ExtIRQ), 1);
    chk("single_id", 16'(irq_id), 2);
    ack_it;
    chk("single_ack_irq", 16'(ExtIRQ), 0);
    chk("single_ack_pend", 16'(pending), 0);
    tick;
    chk("single_gap1", 16'(ExtIRQ), 0);
    tick;
    chk("single_gap2", 16'(ExtIRQ), 0);
    // priority
    src = 4'b1010; exp_q.push_back(1); exp_q.push_back(3);
    tick;
    chk("prio_pend", 16'(pending), 16'b1010);
    src = 0;
    tick;
    chk("prio_first", 16'(irq_id), 1);
    ack_it;
    chk("prio_ack_pend", 16'(pending), 16'b1000);
    chk("prio_ack_irq", 16'(ExtIRQ), 0);
    tick;
    chk("prio_gap", 16'(ExtIRQ), 0);
    tick;
    chk("prio_second_irq", 16'(ExtIRQ), 1);
    chk("prio_second", 16'(irq_id), 3);
    ack_it;
    tick;
    tick;
    // masking
    mask = 4'b1110;
    src = 4'b0001;
    tick;
    src = 0;
    tick;
    tick;
    chk("mask_pend", 16'(pending), 16'b0001);
    chk("mask_irq", 16'(ExtIRQ), 0);
    mask = 4'b1111; exp_q.push_back(0);
    tick;
    tick;
    chk("unmask_irq", 16'(ExtIRQ), 1);
    chk("unmask_id", 16'(irq_id), 0);
    mask = 4'b1110;
    tick;
    chk("mask_in_req", 16'(ExtIRQ), 1);
    chk("mask_in_req_id", 16'(irq_id), 0);
    mask = 4'b1111;
    ack_it;
    tick;
    tick;
    // lost and coincidence
    src = 4'b0010; exp_q.push_back(1);
    tick;
    src = 0;
    tick;
    chk("lost_req", 16'(ExtIRQ), 1);
    src = 4'b0010;
    tick;
    chk("lost_set", 16'(lost), 16'b0010);
    chk("lost_pend", 16'(pending), 16'b0010);
    src = 0;
    tick;
    lost_clr = 4'b0010;
    tick;
    lost_clr = 0;
    chk("lost_clr", 16'(lost), 0);
    src = 4'b0010; exp_q.push_back(1);
    ack_it;
    src = 0;
    chk("coinc_pend", 16'(pending), 16'b0010);
    chk("coinc_lost", 16'(lost), 0);
    chk("coinc_irq", 16'(ExtIRQ), 0);
    tick;
    tick;
    chk("coinc_rereq", 16'(ExtIRQ), 1);
    chk("coinc_id", 16'(irq_id), 1);
    ack_it;
    tick;
    tick;
    chk("coinc_done_pend", 16'(pending), 0);
    // reset mid-request
    src = 4'b0001; exp_q.push_back(0);
    tick;
    src = 0;
    tick;
    chk("rreq_irq", 16'(ExtIRQ), 1);
    src = 4'b0100;
    tick;
    src = 0;
    tick;
    src = 4'b0100;
    tick;
    chk("rreq_lost", 16'(lost), 16'b0100);
    src = 0;
    tick;
    reset = 1;
    #1;
    chk("async_irq", 16'(ExtIRQ), 0);
    chk("async_pend", 16'(pending), 0);
    chk("async_lost", 16'(lost), 0);
    src = 4'b1000;
    tick;
    reset = 0;
    repeat (4) tick;
    chk("held_irq", 16'(ExtIRQ), 0);
    chk("held_pend", 16'(pending), 0);
    chk("sb_empty", 16'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
